spi_slave_if: RTL and testbench

- SPI slave front-end for the single-port RAM. It deserialises MOSI frames into 10-bit command words `{cmd[1:0], payload[7:0]}` on `rx_data` and pulses `rx_valid`.
- For read-data commands it accepts the RAM's `tx_data`/`tx_valid` response and serialises it MSB-first on MISO.
- It sits between the SPI pins and the RAM in the top-level wrapper, and is the initiator end of the RAM's `din`/`rx_valid`/`dout`/`tx_valid` interface.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_piso_shifter.sv | 56 +++++
 rtl/spi_slave_if.sv | 127 ++++++++++++
 tb/tb_spi_slave_if.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front-end and its RAM.
package spi_pkg;

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} spi_state_e;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  // Command codes carried in rx_data[9:8]; decoded by the RAM, not here.
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_piso_shifter.sv
// Load/shift-out register for the MISO read response, MSB first.
// The loaded MSB appears on o_bit at the load edge; after the last bit
// one extra edge returns o_bit to 0 (o_last flags that edge).
module spi_piso_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  output logic         o_bit,
  output logic         o_busy,
  output logic         o_last
);
  localparam int CW = $clog2(W);

  logic [W-1:0]  r_sr;
  logic [CW-1:0] r_cnt;
  logic          r_bit;
  logic          r_busy;

  // Abort has priority; a load is only honoured while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_bit  <= 1'b0;
      r_busy <= 1'b0;
    end else if (i_clr) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_bit  <= 1'b0;
      r_busy <= 1'b0;
    end else if (i_load && !r_busy) begin
      r_sr   <= {i_data[W-2:0], 1'b0};
      r_bit  <= i_data[W-1];
      r_cnt  <= CW'(W-1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_bit <= r_sr[W-1];
        r_sr  <= r_sr << 1;
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_bit  <= 1'b0;
        r_busy <= 1'b0;
      end
    end
  end

  assign o_bit  = r_bit;
  assign o_busy = r_busy;
  assign o_last = r_busy && (r_cnt == '0);

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front-end: deserialises {selector, cmd[1:0], payload[7:0]}
// MOSI frames onto rx_data/rx_valid and serialises RAM read data on MISO.
// Optional macro SPI_SLAVE_PROTO_CHECK_EN adds the proto_err output and
// an idle-stability check on the receive shift register.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int FRAME_W = spi_pkg::FRAME_W,
  parameter int DATA_W  = spi_pkg::DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic               rx_valid
`ifdef SPI_SLAVE_PROTO_CHECK_EN
  ,
  output logic               proto_err
`endif
);

  spi_state_e         r_state;
  logic [3:0]         r_cnt;
  logic               r_rx_done;      // receive phase finished, ignore MOSI
  logic               r_wait_tx;      // READ_DATA waiting for tx_valid
  logic               r_rd_addr_seen;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;

  logic w_abort;
  logic w_load;
  logic w_miso;
  logic w_busy;
  logic w_last;

  assign w_abort = (r_state != IDLE) && SS_n;
  assign w_load  = (r_state == READ_DATA) && r_wait_tx && tx_valid && !SS_n && !w_busy;

  spi_piso_shifter #(.W(DATA_W)) u_piso (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_abort),
    .i_load (w_load),
    .i_data (tx_data),
    .o_bit  (w_miso),
    .o_busy (w_busy),
    .o_last (w_last)
  );

  // Main FSM: frame sequencing, receive shift, rx_valid pulse, read tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_rx_done      <= 1'b0;
      r_wait_tx      <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_abort) begin
        // Deselect: drop back to IDLE; rd_addr_seen survives an aborted read.
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_rx_done <= 1'b0;
        r_wait_tx <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt     <= '0;
            r_rx_done <= 1'b0;
            if (!SS_n) r_state <= CHK_CMD;
          end
          CHK_CMD: begin
            if (!MOSI)               r_state <= WRITE;
            else if (r_rd_addr_seen) r_state <= READ_DATA;
            else                     r_state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!r_rx_done) begin
              r_rx_data <= {r_rx_data[FRAME_W-2:0], MOSI};
              if (r_cnt == 4'(FRAME_W-1)) begin
                r_cnt      <= '0;
                r_rx_valid <= 1'b1;
                r_rx_done  <= 1'b1;
                if (r_state == READ_ADD)  r_rd_addr_seen <= 1'b1;
                if (r_state == READ_DATA) r_wait_tx      <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else if (r_state == READ_DATA) begin
              if (w_load) r_wait_tx      <= 1'b0;
              if (w_last) r_rd_addr_seen <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign MISO     = w_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

`ifdef SPI_SLAVE_PROTO_CHECK_EN
  logic r_proto_err;

  // Flag deselect during an unfinished receive or an outstanding response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_proto_err <= 1'b0;
    else     r_proto_err <= w_abort && (!r_rx_done || r_wait_tx || w_busy);
  end

  assign proto_err = r_proto_err;

  // Receive shift register must not move while the FSM sits in IDLE.
  a_idle_stable: assert property (@(posedge clk) disable iff (rst)
    (r_state == IDLE) |=> $stable(r_rx_data));
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed self-checking bench for spi_slave_if.
module tb_spi_slave_if;
  import spi_pkg::*;

  logic       clk, rst, SS_n, MOSI, MISO, tx_valid, rx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data;
`ifdef SPI_SLAVE_PROTO_CHECK_EN
  logic       proto_err;
`endif

  int checks   = 0;
  int failures = 0;

  spi_slave_if dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .rx_valid (rx_valid)
`ifdef SPI_SLAVE_PROTO_CHECK_EN
    ,
    .proto_err(proto_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full frame from IDLE: select, selector bit, 10 bits MSB first.
  task automatic frame(input logic sel, input logic [9:0] w, input string tag);
    SS_n = 1'b0;
    tick();
    check({tag, "_chk"}, 32'(dut.r_state), 32'(CHK_CMD));
    MOSI = sel;
    tick();
    for (int i = 9; i >= 0; i--) begin
      MOSI = w[i];
      tick();
      check({tag, "_vld"}, 32'(rx_valid), 32'(i == 0));
      check({tag, "_miso"}, 32'(MISO), 32'd0);
    end
    check({tag, "_data"}, 32'(rx_data), 32'(w));
  endtask

  logic [7:0] exp_tx;

  initial begin
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    tick(); tick();
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_rxd", 32'(rx_data), 32'd0);
    check("rst_vld", 32'(rx_valid), 32'd0);
    rst = 1'b0;
    tick();

    // 1: async reset mid WRITE frame at k=5
    SS_n = 1'b0; tick();
    MOSI = 1'b0; tick();
    for (int i = 0; i < 5; i++) begin MOSI = 1'b1; tick(); end
    #2 rst = 1'b1;
    #1;
    check("t1_state", 32'(dut.r_state), 32'(IDLE));
    check("t1_vld", 32'(rx_valid), 32'd0);
    check("t1_miso", 32'(MISO), 32'd0);
    check("t1_rxd", 32'(rx_data), 32'd0);
    SS_n = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t1_novld", 32'(rx_valid), 32'd0);
    end

    // 2: write frame, rx_valid on 12th edge, one cycle wide
    frame(1'b0, {CMD_WR_ADDR, 8'hA5}, "t2");
    tick();
    check("t2_vld_off", 32'(rx_valid), 32'd0);
    check("t2_hold", 32'(rx_data), 32'h0A5);
    SS_n = 1'b1; tick();

    // 3: read-address frame sets rd_addr_seen
    frame(1'b1, {CMD_RD_ADDR, 8'h30}, "t3");
    check("t3_seen", 32'(dut.r_rd_addr_seen), 32'd1);
    tick();
    SS_n = 1'b1; tick();
    check("t3_idle", 32'(dut.r_state), 32'(IDLE));
    check("t3_seen_kept", 32'(dut.r_rd_addr_seen), 32'd1);

    // 4: read-data frame, response C3 after 3 wait cycles
    frame(1'b1, {CMD_RD_DATA, 8'h00}, "t4");
    check("t4_state", 32'(dut.r_state), 32'(READ_DATA));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_wait_miso", 32'(MISO), 32'd0);
    end
    exp_tx = 8'hC3;
    tx_data = 8'hC3; tx_valid = 1'b1;
    tick();
    check("t4_msb", 32'(MISO), 32'(exp_tx[7]));
    for (int i = 6; i >= 0; i--) begin
      // Stray tx_valid while shifting must be ignored.
      if (i == 4) begin tx_valid = 1'b1; tx_data = 8'h00; end
      else tx_valid = 1'b0;
      tick();
      check("t4_bit", 32'(MISO), 32'(exp_tx[i]));
    end
    tx_valid = 1'b0;
    tick();
    check("t4_tail", 32'(MISO), 32'd0);
    check("t4_seen_clr", 32'(dut.r_rd_addr_seen), 32'd0);
    tick();
    check("t4_tail2", 32'(MISO), 32'd0);
    SS_n = 1'b1; tick();

    // 5: deselect during response after 3 bits
    frame(1'b1, {CMD_RD_ADDR, 8'h44}, "t5a");
    tick();
    SS_n = 1'b1; tick();
    frame(1'b1, {CMD_RD_DATA, 8'h00}, "t5b");
    exp_tx = 8'hA5;
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("t5_b7", 32'(MISO), 32'(exp_tx[7]));
    tick();
    check("t5_b6", 32'(MISO), 32'(exp_tx[6]));
    tick();
    check("t5_b5", 32'(MISO), 32'(exp_tx[5]));
    SS_n = 1'b1;
    tick();
    check("t5_miso0", 32'(MISO), 32'd0);
    check("t5_idle", 32'(dut.r_state), 32'(IDLE));
    check("t5_seen", 32'(dut.r_rd_addr_seen), 32'd1);
`ifdef SPI_SLAVE_PROTO_CHECK_EN
    check("t5_perr", 32'(proto_err), 32'd1);
`endif
    tick();
    check("t5_miso_idle", 32'(MISO), 32'd0);
`ifdef SPI_SLAVE_PROTO_CHECK_EN
    check("t5_perr_off", 32'(proto_err), 32'd0);
`endif

    // 6: tx_valid in IDLE/WRITE ignored; back-to-back frames
    tx_valid = 1'b1; tx_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_idle_miso", 32'(MISO), 32'd0);
    end
    frame(1'b0, {CMD_WR_DATA, 8'h55}, "t6a");
    tick();
    check("t6a_off", 32'(rx_valid), 32'd0);
    SS_n = 1'b1; tick();
    frame(1'b0, {CMD_RD_ADDR, 8'hAA}, "t6b");
    tick();
    check("t6b_off", 32'(rx_valid), 32'd0);
    check("t6b_miso", 32'(MISO), 32'd0);
    tx_valid = 1'b0;
    SS_n = 1'b1; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
